// File: rtl/arith_reservation_station.sv
// arith_reservation_station
//   Data-capture issue queue that sits in front of arithmetic_pipeline. Dispatched
//   ALU ops wait here until operands A, B and the flags operand are all available.
//   The queue snoops the result bus (CDB) for wakeups. Each cycle it issues the
//   oldest fully-ready entry.
//
//   Entries are kept as a collapsing queue:
//     - Slot 0 holds the oldest entry.
//     - Slots [0, count) are occupied.
//     - Removing an entry shifts the younger entries down one slot.
//     - A new dispatch is appended at the tail.
//   This keeps strict acceptance order without age tags.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               drop every entry and any same-cycle dispatch
//   disp_*              dispatch request/payload; disp_ready = (count < DEPTH)
//   cdb_*               result broadcast: value tag/value and flags tag/value
//   issue_*             selected op toward the pipeline; data is 0 when issue_valid=0
module arith_reservation_station #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       disp_valid,
  output logic       disp_ready,
  input  logic [3:0] disp_opcode,
  input  logic [4:0] disp_rob,
  input  logic [4:0] disp_dest,
  input  logic [4:0] disp_flag_dest,
  input  logic [7:0] disp_arch_dest,
  input  logic [4:0] disp_a_tag,
  input  logic [4:0] disp_b_tag,
  input  logic [4:0] disp_f_tag,
  input  logic       disp_a_rdy,
  input  logic       disp_b_rdy,
  input  logic       disp_f_rdy,
  input  logic [7:0] disp_a_val,
  input  logic [7:0] disp_b_val,
  input  logic [7:0] disp_f_val,
  input  logic       cdb_valid,
  input  logic [4:0] cdb_tag,
  input  logic [7:0] cdb_val,
  input  logic [4:0] cdb_flag_tag,
  input  logic [7:0] cdb_flag_val,
  output logic       issue_valid,
  output logic [3:0] issue_opcode,
  output logic [4:0] issue_rob,
  output logic [4:0] issue_dest,
  output logic [4:0] issue_flag_dest,
  output logic [7:0] issue_a_val,
  output logic [7:0] issue_b_val,
  output logic [7:0] issue_f_val,
  output logic [7:0] issue_arch_dest
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [3:0] opcode;
    logic [4:0] rob;
    logic [4:0] dest;
    logic [4:0] flag_dest;
    logic [7:0] arch_dest;
    logic [4:0] a_tag;
    logic [4:0] b_tag;
    logic [4:0] f_tag;
    logic       a_rdy;
    logic       b_rdy;
    logic       f_rdy;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] f_val;
  } ent_t;

  // Capture any waiting operand whose tag is on the CDB this cycle. A and B are
  // compared independently, so one broadcast can satisfy both.
  function automatic ent_t wake(input ent_t e, input logic v,
                                input logic [4:0] t,  input logic [7:0] d,
                                input logic [4:0] ft, input logic [7:0] fd);
    ent_t r;
    r = e;
    if (v && !e.a_rdy && e.a_tag == t) begin
      r.a_rdy = 1'b1;
      r.a_val = d;
    end
    if (v && !e.b_rdy && e.b_tag == t) begin
      r.b_rdy = 1'b1;
      r.b_val = d;
    end
    if (v && !e.f_rdy && e.f_tag == ft) begin
      r.f_rdy = 1'b1;
      r.f_val = fd;
    end
    return r;
  endfunction

  ent_t          ent_p0 [DEPTH];
  ent_t          woken  [DEPTH];
  ent_t          ent_n  [DEPTH];
  ent_t          disp_raw;
  ent_t          disp_ent;
  ent_t          sel_ent;
  logic [CW-1:0] count_p0;
  logic [CW-1:0] count_n;
  logic [CW-1:0] ins_pos;
  logic          sel_found;
  int            sel_i;
  logic          disp_fire;

  assign disp_ready = (count_p0 < DEPTH_C);

  // Oldest-ready select, built from registered state only.
  // The downward scan leaves the lowest ready slot (the oldest) as the winner.
  always_comb begin
    sel_found = 1'b0;
    sel_i     = 0;
    sel_ent   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(count_p0) && ent_p0[i].a_rdy && ent_p0[i].b_rdy && ent_p0[i].f_rdy) begin
        sel_found = 1'b1;
        sel_i     = i;
        sel_ent   = ent_p0[i];
      end
    end
  end

  assign issue_valid     = sel_found;
  assign issue_opcode    = sel_ent.opcode;
  assign issue_rob       = sel_ent.rob;
  assign issue_dest      = sel_ent.dest;
  assign issue_flag_dest = sel_ent.flag_dest;
  assign issue_a_val     = sel_ent.a_val;
  assign issue_b_val     = sel_ent.b_val;
  assign issue_f_val     = sel_ent.f_val;
  assign issue_arch_dest = sel_ent.arch_dest;

  // The incoming op is run through the same CDB compare as resident entries,
  // so a broadcast coinciding with dispatch is not missed.
  always_comb begin
    disp_raw           = '0;
    disp_raw.opcode    = disp_opcode;
    disp_raw.rob       = disp_rob;
    disp_raw.dest      = disp_dest;
    disp_raw.flag_dest = disp_flag_dest;
    disp_raw.arch_dest = disp_arch_dest;
    disp_raw.a_tag     = disp_a_tag;
    disp_raw.b_tag     = disp_b_tag;
    disp_raw.f_tag     = disp_f_tag;
    disp_raw.a_rdy     = disp_a_rdy;
    disp_raw.b_rdy     = disp_b_rdy;
    disp_raw.f_rdy     = disp_f_rdy;
    disp_raw.a_val     = disp_a_val;
    disp_raw.b_val     = disp_b_val;
    disp_raw.f_val     = disp_f_val;
    disp_ent = wake(disp_raw, cdb_valid, cdb_tag, cdb_val, cdb_flag_tag, cdb_flag_val);
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(ent_p0[i], cdb_valid, cdb_tag, cdb_val, cdb_flag_tag, cdb_flag_val);
    end
  end

  // Next queue image:
  //   1. Wake every resident entry against the CDB.
  //   2. Close the gap left by the issued entry by shifting younger entries down.
  //   3. Append the dispatch at the new tail.
  always_comb begin
    disp_fire = disp_valid && disp_ready && !flush;
    ins_pos   = count_p0 - CW'(sel_found);
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = woken[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (sel_found && i >= sel_i) begin
        ent_n[i] = woken[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && i == int'(ins_pos)) begin
        ent_n[i] = disp_ent;
      end
    end
    count_n = count_p0 - CW'(sel_found) + CW'(disp_fire);
  end

  // ---- stage p0: occupancy (control, reset) and entry payload (no reset) ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= count_n;
    end
  end

  // Slots at or above count are never read, so payload needs no reset.
  always_ff @(posedge clk) begin
    ent_p0 <= ent_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_p0 <= DEPTH_C);
      assert (!(sel_found && count_p0 == '0));
      assert (!(disp_fire && !sel_found && count_p0 == DEPTH_C));
    end
  end

endmodule

// File: tb/tb_arith_reservation_station.sv
module tb_arith_reservation_station;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       disp_valid, disp_ready;
  logic [3:0] disp_opcode;
  logic [4:0] disp_rob, disp_dest, disp_flag_dest;
  logic [7:0] disp_arch_dest;
  logic [4:0] disp_a_tag, disp_b_tag, disp_f_tag;
  logic       disp_a_rdy, disp_b_rdy, disp_f_rdy;
  logic [7:0] disp_a_val, disp_b_val, disp_f_val;
  logic       cdb_valid;
  logic [4:0] cdb_tag, cdb_flag_tag;
  logic [7:0] cdb_val, cdb_flag_val;
  logic       issue_valid;
  logic [3:0] issue_opcode;
  logic [4:0] issue_rob, issue_dest, issue_flag_dest;
  logic [7:0] issue_a_val, issue_b_val, issue_f_val, issue_arch_dest;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  arith_reservation_station #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_rob(disp_rob), .disp_dest(disp_dest),
    .disp_flag_dest(disp_flag_dest), .disp_arch_dest(disp_arch_dest),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_f_tag(disp_f_tag),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy), .disp_f_rdy(disp_f_rdy),
    .disp_a_val(disp_a_val), .disp_b_val(disp_b_val), .disp_f_val(disp_f_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_flag_tag(cdb_flag_tag), .cdb_flag_val(cdb_flag_val),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rob(issue_rob),
    .issue_dest(issue_dest), .issue_flag_dest(issue_flag_dest),
    .issue_a_val(issue_a_val), .issue_b_val(issue_b_val), .issue_f_val(issue_f_val),
    .issue_arch_dest(issue_arch_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    assert (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    flush        = 1'b0;
    disp_valid   = 1'b0;
    disp_opcode  = '0; disp_rob = '0; disp_dest = '0; disp_flag_dest = '0; disp_arch_dest = '0;
    disp_a_tag   = '0; disp_b_tag = '0; disp_f_tag = '0;
    disp_a_rdy   = 1'b0; disp_b_rdy = 1'b0; disp_f_rdy = 1'b0;
    disp_a_val   = '0; disp_b_val = '0; disp_f_val = '0;
    cdb_valid    = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_flag_tag = '0; cdb_flag_val = '0;
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] rob,
                      input logic [4:0] at, input logic ar, input logic [7:0] av,
                      input logic [4:0] bt, input logic br, input logic [7:0] bv,
                      input logic [4:0] ft, input logic fr, input logic [7:0] fv);
    disp_valid     = 1'b1;
    disp_opcode    = op;
    disp_rob       = rob;
    disp_dest      = rob + 5'd1;
    disp_flag_dest = rob + 5'd2;
    disp_arch_dest = {3'b000, rob};
    disp_a_tag = at; disp_a_rdy = ar; disp_a_val = av;
    disp_b_tag = bt; disp_b_rdy = br; disp_b_val = bv;
    disp_f_tag = ft; disp_f_rdy = fr; disp_f_val = fv;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [7:0] v,
                     input logic [4:0] ft, input logic [7:0] fv);
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v; cdb_flag_tag = ft; cdb_flag_val = fv;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_disp_ready",  32'(disp_ready), 1);
    chk("rst_issue_rob",   32'(issue_rob), 0);
    chk("rst_issue_a",     32'(issue_a_val), 0);
    chk("rst_count",       32'(dut.count_p0), 0);
    rst = 1'b0;

    // Case 1: all-ready ADD issues next cycle; a second op dispatched while it issues.
    disp(4'd1, 5'd3, 5'd0, 1'b1, 8'd5, 5'd0, 1'b1, 8'd7, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t1_valid", 32'(issue_valid), 1);
    chk("t1_a",     32'(issue_a_val), 5);
    chk("t1_b",     32'(issue_b_val), 7);
    chk("t1_rob",   32'(issue_rob), 3);
    chk("t1_op",    32'(issue_opcode), 1);
    chk("t1_dest",  32'(issue_dest), 4);
    chk("t1_fdest", 32'(issue_flag_dest), 5);
    chk("t1_arch",  32'(issue_arch_dest), 3);
    disp(4'd2, 5'd6, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd2, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t1_sim_valid", 32'(issue_valid), 1);
    chk("t1_sim_rob",   32'(issue_rob), 6);
    chk("t1_sim_count", 32'(dut.count_p0), 1);
    tick();
    chk("t1_end_valid", 32'(issue_valid), 0);
    chk("t1_end_count", 32'(dut.count_p0), 0);
    chk("t1_end_a_zero", 32'(issue_a_val), 0);

    // Case 2: A waits on tag 9, woken by the CDB.
    disp(4'd3, 5'd4, 5'd9, 1'b0, 8'd0, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t2_wait_valid", 32'(issue_valid), 0);
    chk("t2_wait_count", 32'(dut.count_p0), 1);
    cdb(5'd9, 8'h42, 5'd31, 8'h00);
    tick();
    chk("t2_valid", 32'(issue_valid), 1);
    chk("t2_a",     32'(issue_a_val), 32'h42);
    chk("t2_rob",   32'(issue_rob), 4);
    tick();

    // Case 3: younger ready entry issues before older waiting one.
    disp(4'd4, 5'd10, 5'd4, 1'b0, 8'd0, 5'd0, 1'b1, 8'd2, 5'd0, 1'b1, 8'd0);
    tick();
    disp(4'd5, 5'd11, 5'd0, 1'b1, 8'd8, 5'd0, 1'b1, 8'd9, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t3_first_valid", 32'(issue_valid), 1);
    chk("t3_first_rob",   32'(issue_rob), 11);
    cdb(5'd4, 8'h33, 5'd31, 8'h00);
    tick();
    chk("t3_second_valid", 32'(issue_valid), 1);
    chk("t3_second_rob",   32'(issue_rob), 10);
    chk("t3_second_a",     32'(issue_a_val), 32'h33);
    tick();
    chk("t3_end_count", 32'(dut.count_p0), 0);

    // Case 4: fill, overflow attempt ignored, wake one, slot frees.
    for (int i = 0; i < 8; i++) begin
      chk("t4_fill_ready", 32'(disp_ready), 1);
      disp(4'd6, 5'(i), 5'(16 + i), 1'b0, 8'd0, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
      tick();
    end
    chk("t4_full_ready", 32'(disp_ready), 0);
    chk("t4_full_count", 32'(dut.count_p0), 8);
    disp(4'd7, 5'd31, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t4_extra_count", 32'(dut.count_p0), 8);
    chk("t4_extra_valid", 32'(issue_valid), 0);
    cdb(5'd18, 8'h55, 5'd31, 8'h00);
    tick();
    chk("t4_wake_valid", 32'(issue_valid), 1);
    chk("t4_wake_rob",   32'(issue_rob), 2);
    chk("t4_wake_a",     32'(issue_a_val), 32'h55);
    chk("t4_wake_ready", 32'(disp_ready), 0);
    tick();
    chk("t4_after_ready", 32'(disp_ready), 1);
    chk("t4_after_count", 32'(dut.count_p0), 7);
    flush = 1'b1;
    tick();
    chk("t4_flush_count", 32'(dut.count_p0), 0);

    // Case 5: wakeup in the dispatch cycle.
    disp(4'd8, 5'd5, 5'd6, 1'b0, 8'd0, 5'd0, 1'b1, 8'd3, 5'd0, 1'b1, 8'd0);
    cdb(5'd6, 8'h11, 5'd31, 8'h00);
    tick();
    chk("t5_valid", 32'(issue_valid), 1);
    chk("t5_a",     32'(issue_a_val), 32'h11);
    chk("t5_rob",   32'(issue_rob), 5);
    tick();

    // Flags operand wakeup.
    disp(4'd9, 5'd20, 5'd0, 1'b1, 8'd3, 5'd0, 1'b1, 8'd4, 5'd7, 1'b0, 8'd0);
    tick();
    chk("flag_wait_valid", 32'(issue_valid), 0);
    cdb(5'd30, 8'h00, 5'd7, 8'h80);
    tick();
    chk("flag_valid", 32'(issue_valid), 1);
    chk("flag_f",     32'(issue_f_val), 32'h80);
    chk("flag_rob",   32'(issue_rob), 20);
    tick();

    // A and B waiting on the same tag.
    disp(4'd10, 5'd21, 5'd12, 1'b0, 8'd0, 5'd12, 1'b0, 8'd0, 5'd0, 1'b1, 8'd0);
    tick();
    chk("ab_wait_valid", 32'(issue_valid), 0);
    cdb(5'd12, 8'h09, 5'd31, 8'h00);
    tick();
    chk("ab_valid", 32'(issue_valid), 1);
    chk("ab_a",     32'(issue_a_val), 9);
    chk("ab_b",     32'(issue_b_val), 9);
    tick();

    // Case 6: flush with a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(4'd11, 5'(12 + i), 5'd25, 1'b0, 8'd0, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
      tick();
    end
    chk("t6_pending_count", 32'(dut.count_p0), 3);
    flush = 1'b1;
    disp(4'd12, 5'd15, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
    tick();
    chk("t6_count", 32'(dut.count_p0), 0);
    chk("t6_valid", 32'(issue_valid), 0);
    chk("t6_ready", 32'(disp_ready), 1);
    tick();
    chk("t6_never_issue", 32'(issue_valid), 0);

    // Reset mid-operation drops a ready entry and a same-cycle dispatch.
    disp(4'd13, 5'd22, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
    tick();
    chk("rst_mid_pre_valid", 32'(issue_valid), 1);
    rst = 1'b1;
    disp(4'd14, 5'd23, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd1, 5'd0, 1'b1, 8'd0);
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(issue_valid), 0);
    chk("rst_mid_count", 32'(dut.count_p0), 0);
    tick();
    chk("rst_mid_after_valid", 32'(issue_valid), 0);

    if (fail_cnt != 0) $display("%0d checks did not match", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
